// File: rtl/mem_if_pkg.sv
// Shared types for the single-port memory requester: FSM states and the core request record.
package mem_if_pkg;

  localparam int unsigned WORD_BYTES     = 4;
  localparam int unsigned WORD_BITS      = WORD_BYTES * 8;
  localparam int unsigned DEF_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StCapt,
    StGap
  } mem_init_state_e;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [WORD_BITS-1:0]      wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating up-counter with synchronous clear; expired once the count reaches LIMIT-1.
// LIMIT = 0 disables expiry entirely.
module mem_timeout_ctr #(
  parameter int unsigned LIMIT     = 1024,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= W'(RESET_VAL);
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign expired = (LIMIT != 0) && (32'(count_q) >= LIMIT - 1);

endmodule

// File: rtl/mem_initiator.sv
// Requester side of the read/write/resp memory protocol: one core request at a time,
// level strobes held until mem_resp, single-cycle registered response to the core.
module mem_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WORD_BITS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  mem_init_state_e state_q, state_d;

  logic                  we_q;
  logic                  req_ready_q, rsp_valid_q, rsp_err_q, mem_read_q, mem_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, mem_wdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  timeout_hit, gap_done;

  mem_timeout_ctr #(
    .LIMIT    (TIMEOUT),
    .RESET_VAL(0)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != StReq),
    .enable (state_q == StReq),
    .expired(timeout_hit)
  );

  // Reset leaves this counter already expired, so the post-reset GAP lasts one cycle.
  mem_timeout_ctr #(
    .LIMIT    (GAP_CYCLES),
    .RESET_VAL(GAP_CYCLES)
  ) u_gap_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != StGap),
    .enable (state_q == StGap),
    .expired(gap_done)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid) state_d = StReq;
      StReq: begin
        if (mem_resp) begin
          state_d = we_q ? StGap : StCapt;
        end else if (timeout_hit) begin
          state_d = StGap;
        end
      end
      StCapt: state_d = StGap;
      StGap:  if (gap_done) state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StGap;
      we_q        <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == StIdle);
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q        <= req_we;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_wdata;
            mem_read_q  <= ~req_we;
            mem_write_q <= req_we;
          end
        end
        StReq: begin
          // mem_resp takes priority over a coincident timeout.
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end else if (timeout_hit) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        StCapt: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= mem_rdata;
        end
        StGap: ;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a byte-addressed memory model of programmable delay.
module tb_mem_initiator;
  import mem_if_pkg::*;

  localparam int unsigned TIMEOUT    = 8;
  localparam int unsigned GAP_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_initiator #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT   (TIMEOUT),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp (mem_resp)
  );

  // Memory model: starts on a strobe rising edge, pulses resp after `delay` cycles,
  // drives read data only in the cycle after resp (garbage otherwise).
  logic [7:0]  mem [0:255];
  logic        model_resp, spur_resp, mem_en;
  logic        rd_q, wr_q, busy, pend_rd, is_rd;
  int          cnt, delay;
  logic [7:0]  m_a;

  assign mem_resp = model_resp | spur_resp;

  always @(posedge clk) begin
    rd_q       <= mem_read;
    wr_q       <= mem_write;
    model_resp <= 1'b0;
    pend_rd    <= 1'b0;
    mem_rdata  <= 32'hBAD0_BAD0;
    if (!rst_n) begin
      busy <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h11; mem[1] <= 8'h22; mem[2] <= 8'h33; mem[3] <= 8'h44;
      mem[4] <= 8'h55; mem[5] <= 8'h66; mem[6] <= 8'h77; mem[7] <= 8'h88;
    end else begin
      if (pend_rd) mem_rdata <= {mem[m_a + 8'd3], mem[m_a + 8'd2], mem[m_a + 8'd1], mem[m_a]};
      if (busy) begin
        if (cnt <= 1) begin
          model_resp <= 1'b1;
          busy       <= 1'b0;
          if (is_rd) begin
            pend_rd <= 1'b1;
          end else begin
            mem[m_a]        <= mem_wdata[7:0];
            mem[m_a + 8'd1] <= mem_wdata[15:8];
            mem[m_a + 8'd2] <= mem_wdata[23:16];
            mem[m_a + 8'd3] <= mem_wdata[31:24];
          end
        end else begin
          cnt <= cnt - 1;
        end
      end else if (mem_en && ((mem_read && !rd_q) || (mem_write && !wr_q))) begin
        busy  <= 1'b1;
        cnt   <= delay;
        is_rd <= mem_read;
        m_a   <= mem_addr[7:0];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (!req_ready) check({name, " ready wait"}, req_ready, 1);
  endtask

  // One transaction from handshake to response; latency counted in cycles after the
  // handshake cycle, strobe count is the number of cycles mem_read|mem_write was high.
  task automatic do_txn(input string name, input mem_req_t rq, input int d,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_strb);
    int n, strb;
    logic got;
    delay     = d;
    req_we    = rq.we;
    req_addr  = rq.addr;
    req_wdata = rq.wdata;
    req_valid = 1'b1;
    wait_ready(name);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFF0;
    req_wdata = 32'h5555_AAAA;
    n = 0; strb = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({name, " mem_addr"}, mem_addr, rq.addr);
        check({name, " strobe dir"}, {mem_read, mem_write}, {~rq.we, rq.we});
        if (rq.we) check({name, " mem_wdata"}, mem_wdata, rq.wdata);
      end
      if (mem_read || mem_write) strb++;
      if (rsp_valid) got = 1'b1;
    end
    check({name, " rsp seen"}, got, 1'b1);
    check({name, " latency"}, n, exp_lat);
    check({name, " strobe cycles"}, strb, exp_strb);
    check({name, " rdata"}, rsp_rdata, exp_rdata);
    check({name, " err"}, rsp_err, exp_err);
    @(negedge clk);
    check({name, " rsp pulse"}, {rsp_valid, rsp_err}, 2'b00);
    check({name, " rdata hold"}, rsp_rdata, exp_rdata);
  endtask

  typedef struct packed {
    mem_req_t    req;
    int unsigned delay;
    logic [31:0] exp_rdata;
    int unsigned exp_lat;
    int unsigned exp_strb;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, nrsp, low_run, gap_len, bad;
    logic seen_high, in_gap, go;
    logic [31:0] rsp_data [2];

    // Resp lands in REQ cycle k = delay+2; read latency k+2, write k+1, strobes k cycles.
    vecs[0] = '{'{1'b0, 32'h0, 32'h0},          3, 32'h4433_2211, 7,  5};
    vecs[1] = '{'{1'b0, 32'h4, 32'h0},          1, 32'h8877_6655, 5,  3};
    vecs[2] = '{'{1'b1, 32'h8, 32'hDEAD_BEEF},  2, 32'h0,         5,  4};
    vecs[3] = '{'{1'b0, 32'h8, 32'h0},          4, 32'hDEAD_BEEF, 8,  6};
    vecs[4] = '{'{1'b1, 32'hC, 32'h0123_4567},  5, 32'h0,         8,  7};
    vecs[5] = '{'{1'b0, 32'hC, 32'h0},          2, 32'h0123_4567, 6,  4};
    vecs[6] = '{'{1'b0, 32'h4, 32'h0},          6, 32'h8877_6655, 10, 8};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    spur_resp = 1'b0; mem_en = 1'b1; delay = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {req_ready, rsp_valid, rsp_err, mem_read, mem_write}, 5'b0);
    check("reset rdata/addr", {rsp_rdata, mem_addr}, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready after reset release", req_ready, 1'b0);
    @(negedge clk);
    check("ready one cycle later", req_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].req, int'(vecs[i].delay), vecs[i].exp_rdata,
             1'b0, int'(vecs[i].exp_lat), int'(vecs[i].exp_strb));
    end

    // Back-to-back reads with req_valid held across both handshakes.
    delay = 2; req_we = 1'b0; req_addr = 32'h0; req_valid = 1'b1;
    hs = 0; nrsp = 0; low_run = 0; gap_len = -1; seen_high = 1'b0; in_gap = 1'b0;
    rsp_data[0] = '0; rsp_data[1] = '0;
    for (int c = 0; c < 60 && nrsp < 2; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_data[nrsp] = rsp_rdata;
        nrsp++;
      end
      if (mem_read) begin
        if (in_gap) begin
          gap_len = low_run;
          in_gap  = 1'b0;
        end
        seen_high = 1'b1;
      end else if (seen_high && gap_len < 0) begin
        in_gap = 1'b1;
        low_run++;
      end
      go = req_ready && req_valid;
      @(posedge clk);
      #1;
      if (go) begin
        hs++;
        if (hs == 1) req_addr = 32'h4;
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b responses", nrsp, 2);
    check("b2b first data", rsp_data[0], 32'h4433_2211);
    check("b2b second data", rsp_data[1], 32'h8877_6655);
    check("b2b strobe low gap", gap_len, GAP_CYCLES + 2);

    // No memory response at all: error exactly after TIMEOUT REQ cycles.
    mem_en = 1'b0;
    do_txn("timeout", '{1'b0, 32'h10, 32'h0}, 1, 32'h0, 1'b1, TIMEOUT + 1, TIMEOUT);
    mem_en = 1'b1;
    do_txn("after timeout", '{1'b0, 32'h4, 32'h0}, 2, 32'h8877_6655, 1'b0, 6, 4);

    // Reset in the middle of REQ aborts without a response.
    delay = 5; req_we = 1'b0; req_addr = 32'h4; req_valid = 1'b1;
    wait_ready("rst mid");
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid-reset strobes/flags", {req_ready, rsp_valid, rsp_err, mem_read, mem_write}, 5'b0);
    check("mid-reset addr/wdata", {mem_addr, mem_wdata}, 64'h0);
    check("mid-reset rdata", rsp_rdata, 32'h0);
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    check("no rsp after mid-reset", bad, 0);
    do_txn("read after reset", '{1'b0, 32'h0, 32'h0}, 3, 32'h4433_2211, 1'b0, 7, 5);

    // Spurious mem_resp while idle.
    wait_ready("spurious");
    @(posedge clk);
    #1 spur_resp = 1'b1;
    @(posedge clk);
    #1 spur_resp = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready || mem_read || mem_write) bad++;
    end
    check("spurious resp ignored", bad, 0);
    do_txn("read after spurious", '{1'b0, 32'h4, 32'h0}, 1, 32'h8877_6655, 1'b0, 5, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
